// File: rtl/regstat_pkg.sv
// Shared constants and types for the multi-port register status table.
// Default geometry is 32 architectural registers with a 4-bit ROB tag.
package regstat_pkg;

  localparam int NREGS_DEF = 32;
  localparam int TAG_W_DEF = 4;

  // One table entry: pending-producer flag plus the producer's ROB tag.
  typedef struct packed {
    logic                 busy;
    logic [TAG_W_DEF-1:0] tag;
  } regstat_entry_t;

endpackage

// File: rtl/regstat_read_port.sv
// One source-operand lookup for one issue slot.
// Precedence: newest older slot in the bundle writing the same register,
// then a commit that retires the current producer this cycle (forward),
// then the stored table entry. Register 0 always reads as idle.
module regstat_read_port
  import regstat_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int SLOT     = 0
) (
  input  logic [AW-1:0]                    i_rsAddr,
  input  logic [ISSUE_W-1:0]               i_bundleWe,
  input  logic [ISSUE_W-1:0][AW-1:0]       i_bundleAddr,
  input  logic [ISSUE_W-1:0][TAG_W-1:0]    i_bundleTag,
  input  logic [COMMIT_W-1:0]              i_commitWe,
  input  logic [COMMIT_W-1:0][AW-1:0]      i_commitAddr,
  input  logic [COMMIT_W-1:0][TAG_W-1:0]   i_commitTag,
  input  logic [NREGS-1:0]                 i_tableBusy,
  input  logic [NREGS-1:0][TAG_W-1:0]      i_tableTag,
  output logic                             o_busy,
  output logic [TAG_W-1:0]                 o_tag,
  output logic                             o_fwd
);

  logic             w_bypassHit;
  logic [TAG_W-1:0] w_bypassTag;
  logic             w_commitHit;

  // Resolve the operand: in-bundle bypass, commit forward, or stored state.
  always_comb begin
    w_bypassHit = 1'b0;
    w_bypassTag = '0;
    w_commitHit = 1'b0;
    o_busy      = 1'b0;
    o_tag       = '0;
    o_fwd       = 1'b0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (j < SLOT && i_bundleWe[j] && i_bundleAddr[j] == i_rsAddr) begin
        w_bypassHit = 1'b1;
        w_bypassTag = i_bundleTag[j];
      end
    end
    for (int c = 0; c < COMMIT_W; c++) begin
      if (i_commitWe[c] && i_commitAddr[c] == i_rsAddr &&
          i_tableBusy[i_rsAddr] && i_tableTag[i_rsAddr] == i_commitTag[c]) begin
        w_commitHit = 1'b1;
      end
    end
    if (i_rsAddr == '0) begin
      o_busy = 1'b0;
    end else if (w_bypassHit) begin
      o_busy = 1'b1;
      o_tag  = w_bypassTag;
    end else if (w_commitHit) begin
      o_fwd = 1'b1;
    end else if (i_tableBusy[i_rsAddr]) begin
      o_busy = 1'b1;
      o_tag  = i_tableTag[i_rsAddr];
    end
  end

endmodule

// File: rtl/register_status_mw.sv
// Multi-port register status table: per architectural register, whether a
// producer is in flight and the ROB tag of the newest one. Commits apply
// before issue writes; later issue slots win on the same destination.
// Optional checkpoint/restore is enabled with REGSTAT_CHECKPOINT_EN.
module register_status_mw
  import regstat_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           flush_i,
  input  logic [ISSUE_W-1:0]             issue_valid_i,
  input  logic [ISSUE_W-1:0]             issue_wr_en_i,
  input  logic [ISSUE_W-1:0][AW-1:0]     issue_wr_addr_i,
  input  logic [ISSUE_W-1:0][TAG_W-1:0]  issue_rob_tag_i,
  input  logic [ISSUE_W-1:0][AW-1:0]     issue_rs1_addr_i,
  input  logic [ISSUE_W-1:0][AW-1:0]     issue_rs2_addr_i,
  output logic [ISSUE_W-1:0]             issue_rs1_busy_o,
  output logic [ISSUE_W-1:0][TAG_W-1:0]  issue_rs1_tag_o,
  output logic [ISSUE_W-1:0]             issue_rs1_fwd_o,
  output logic [ISSUE_W-1:0]             issue_rs2_busy_o,
  output logic [ISSUE_W-1:0][TAG_W-1:0]  issue_rs2_tag_o,
  output logic [ISSUE_W-1:0]             issue_rs2_fwd_o,
  input  logic [COMMIT_W-1:0]            commit_wr_en_i,
  input  logic [COMMIT_W-1:0][AW-1:0]    commit_wr_addr_i,
  input  logic [COMMIT_W-1:0][TAG_W-1:0] commit_rob_tag_i
`ifdef REGSTAT_CHECKPOINT_EN
  ,
  input  logic                           ckpt_save_i,
  input  logic                           ckpt_restore_i,
  output logic                           ckpt_valid_o
`endif
);

  logic [NREGS-1:0]            r_busy;
  logic [NREGS-1:0][TAG_W-1:0] r_tag;
  logic [NREGS-1:0]            w_commitBusy;
  logic [NREGS-1:0][TAG_W-1:0] w_commitTag;
  logic [NREGS-1:0]            w_issueBusy;
  logic [NREGS-1:0][TAG_W-1:0] w_issueTag;
  logic [NREGS-1:0]            w_nextBusy;
  logic [NREGS-1:0][TAG_W-1:0] w_nextTag;
  logic [ISSUE_W-1:0]          w_issueWe;

  assign w_issueWe = issue_valid_i & issue_wr_en_i;

  // Apply matching commits to the live table, then layer issue writes on top.
  always_comb begin
    w_commitBusy = r_busy;
    w_commitTag  = r_tag;
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_wr_en_i[c] && commit_wr_addr_i[c] != '0 &&
          r_busy[commit_wr_addr_i[c]] &&
          r_tag[commit_wr_addr_i[c]] == commit_rob_tag_i[c]) begin
        w_commitBusy[commit_wr_addr_i[c]] = 1'b0;
        w_commitTag[commit_wr_addr_i[c]]  = '0;
      end
    end
    w_issueBusy = w_commitBusy;
    w_issueTag  = w_commitTag;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (w_issueWe[k] && issue_wr_addr_i[k] != '0) begin
        w_issueBusy[issue_wr_addr_i[k]] = 1'b1;
        w_issueTag[issue_wr_addr_i[k]]  = issue_rob_tag_i[k];
      end
    end
  end

`ifdef REGSTAT_CHECKPOINT_EN
  logic [NREGS-1:0]            r_snapBusy;
  logic [NREGS-1:0][TAG_W-1:0] r_snapTag;
  logic                        r_ckptValid;
  logic [NREGS-1:0]            w_snapCommitBusy;
  logic [NREGS-1:0][TAG_W-1:0] w_snapCommitTag;
  logic                        w_doRestore;

  assign w_doRestore  = ckpt_restore_i && r_ckptValid;
  assign ckpt_valid_o = r_ckptValid;

  // Retire this cycle's commits against the snapshot so a restore stays current.
  always_comb begin
    w_snapCommitBusy = r_snapBusy;
    w_snapCommitTag  = r_snapTag;
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_wr_en_i[c] && commit_wr_addr_i[c] != '0 &&
          r_snapBusy[commit_wr_addr_i[c]] &&
          r_snapTag[commit_wr_addr_i[c]] == commit_rob_tag_i[c]) begin
        w_snapCommitBusy[commit_wr_addr_i[c]] = 1'b0;
        w_snapCommitTag[commit_wr_addr_i[c]]  = '0;
      end
    end
  end

  // Live next state: flush wins, then restore from snapshot, else normal update.
  always_comb begin
    w_nextBusy = w_issueBusy;
    w_nextTag  = w_issueTag;
    if (flush_i) begin
      w_nextBusy = '0;
      w_nextTag  = '0;
    end else if (w_doRestore) begin
      w_nextBusy = w_snapCommitBusy;
      w_nextTag  = w_snapCommitTag;
    end
  end

  // Snapshot storage: taken on save, kept current by commits while valid.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_snapBusy  <= '0;
      r_snapTag   <= '0;
      r_ckptValid <= 1'b0;
    end else if (flush_i || w_doRestore) begin
      r_ckptValid <= 1'b0;
    end else if (ckpt_save_i) begin
      r_snapBusy  <= w_issueBusy;
      r_snapTag   <= w_issueTag;
      r_ckptValid <= 1'b1;
    end else if (r_ckptValid) begin
      r_snapBusy <= w_snapCommitBusy;
      r_snapTag  <= w_snapCommitTag;
    end
  end
`else
  // Live next state: flush discards the cycle's commits and issues.
  always_comb begin
    w_nextBusy = w_issueBusy;
    w_nextTag  = w_issueTag;
    if (flush_i) begin
      w_nextBusy = '0;
      w_nextTag  = '0;
    end
  end
`endif

  // Live table register; reset clears every entry immediately.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_busy <= '0;
      r_tag  <= '0;
    end else begin
      r_busy <= w_nextBusy;
      r_tag  <= w_nextTag;
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    regstat_read_port #(
      .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .TAG_W(TAG_W),
      .NREGS(NREGS), .AW(AW), .SLOT(k)
    ) u_rs1 (
      .i_rsAddr(issue_rs1_addr_i[k]),
      .i_bundleWe(w_issueWe), .i_bundleAddr(issue_wr_addr_i), .i_bundleTag(issue_rob_tag_i),
      .i_commitWe(commit_wr_en_i), .i_commitAddr(commit_wr_addr_i), .i_commitTag(commit_rob_tag_i),
      .i_tableBusy(r_busy), .i_tableTag(r_tag),
      .o_busy(issue_rs1_busy_o[k]), .o_tag(issue_rs1_tag_o[k]), .o_fwd(issue_rs1_fwd_o[k])
    );
    regstat_read_port #(
      .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .TAG_W(TAG_W),
      .NREGS(NREGS), .AW(AW), .SLOT(k)
    ) u_rs2 (
      .i_rsAddr(issue_rs2_addr_i[k]),
      .i_bundleWe(w_issueWe), .i_bundleAddr(issue_wr_addr_i), .i_bundleTag(issue_rob_tag_i),
      .i_commitWe(commit_wr_en_i), .i_commitAddr(commit_wr_addr_i), .i_commitTag(commit_rob_tag_i),
      .i_tableBusy(r_busy), .i_tableTag(r_tag),
      .o_busy(issue_rs2_busy_o[k]), .o_tag(issue_rs2_tag_o[k]), .o_fwd(issue_rs2_fwd_o[k])
    );
  end

endmodule

// File: tb/tb_register_status_mw.sv
// Directed bench for register_status_mw (2 issue slots, 2 commit ports,
// 4-bit tags, 32 registers). Inputs change on the falling edge and
// outputs are checked 1ns later.
module tb_register_status_mw;

  logic            clk;
  logic            resetN;
  logic            flush;
  logic [1:0]      issueValid;
  logic [1:0]      issueWrEn;
  logic [1:0][4:0] issueWrAddr;
  logic [1:0][3:0] issueRobTag;
  logic [1:0][4:0] issueRs1Addr;
  logic [1:0][4:0] issueRs2Addr;
  logic [1:0]      rs1Busy;
  logic [1:0][3:0] rs1Tag;
  logic [1:0]      rs1Fwd;
  logic [1:0]      rs2Busy;
  logic [1:0][3:0] rs2Tag;
  logic [1:0]      rs2Fwd;
  logic [1:0]      commitWrEn;
  logic [1:0][4:0] commitWrAddr;
  logic [1:0][3:0] commitRobTag;
`ifdef REGSTAT_CHECKPOINT_EN
  logic            ckptSave;
  logic            ckptRestore;
  logic            ckptValid;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  register_status_mw dut (
    .clk_i(clk),
    .reset_ni(resetN),
    .flush_i(flush),
    .issue_valid_i(issueValid),
    .issue_wr_en_i(issueWrEn),
    .issue_wr_addr_i(issueWrAddr),
    .issue_rob_tag_i(issueRobTag),
    .issue_rs1_addr_i(issueRs1Addr),
    .issue_rs2_addr_i(issueRs2Addr),
    .issue_rs1_busy_o(rs1Busy),
    .issue_rs1_tag_o(rs1Tag),
    .issue_rs1_fwd_o(rs1Fwd),
    .issue_rs2_busy_o(rs2Busy),
    .issue_rs2_tag_o(rs2Tag),
    .issue_rs2_fwd_o(rs2Fwd),
    .commit_wr_en_i(commitWrEn),
    .commit_wr_addr_i(commitWrAddr),
    .commit_rob_tag_i(commitRobTag)
`ifdef REGSTAT_CHECKPOINT_EN
    ,
    .ckpt_save_i(ckptSave),
    .ckpt_restore_i(ckptRestore),
    .ckpt_valid_o(ckptValid)
`endif
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic clearInputs();
    flush        = 1'b0;
    issueValid   = '0;
    issueWrEn    = '0;
    issueWrAddr  = '0;
    issueRobTag  = '0;
    issueRs1Addr = '0;
    issueRs2Addr = '0;
    commitWrEn   = '0;
    commitWrAddr = '0;
    commitRobTag = '0;
`ifdef REGSTAT_CHECKPOINT_EN
    ckptSave    = 1'b0;
    ckptRestore = 1'b0;
`endif
  endtask

  // Advance to the next falling edge and start a fresh input cycle.
  task automatic applyStimulus();
    @(negedge clk);
    clearInputs();
  endtask

  task automatic setIssue(input int slot, input logic [4:0] rd, input logic [3:0] tag);
    issueValid[slot]  = 1'b1;
    issueWrEn[slot]   = 1'b1;
    issueWrAddr[slot] = rd;
    issueRobTag[slot] = tag;
  endtask

  task automatic setCommit(input int port, input logic [4:0] rd, input logic [3:0] tag);
    commitWrEn[port]   = 1'b1;
    commitWrAddr[port] = rd;
    commitRobTag[port] = tag;
  endtask

  // Check busy/tag/fwd of one source of one slot (src 1 or 2).
  task automatic checkRead(input int slot, input int src, input string name,
                           input logic expBusy, input logic [3:0] expTag, input logic expFwd);
    if (src == 1) begin
      checkOutput({name, ".busy"}, 32'(rs1Busy[slot]), 32'(expBusy));
      checkOutput({name, ".tag"},  32'(rs1Tag[slot]),  32'(expTag));
      checkOutput({name, ".fwd"},  32'(rs1Fwd[slot]),  32'(expFwd));
    end else begin
      checkOutput({name, ".busy"}, 32'(rs2Busy[slot]), 32'(expBusy));
      checkOutput({name, ".tag"},  32'(rs2Tag[slot]),  32'(expTag));
      checkOutput({name, ".fwd"},  32'(rs2Fwd[slot]),  32'(expFwd));
    end
  endtask

  // Directed scenario sequence.
  initial begin
    clearInputs();
    resetN = 1'b0;
    issueRs1Addr[0] = 5'd5;
    #1;
    checkRead(0, 1, "rst_x5", 1'b0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    clearInputs();
    issueRs1Addr[0] = 5'd5;
    #1;
    checkRead(0, 1, "postrst_x5", 1'b0, 4'd0, 1'b0);

    // Two slots writing x3: slot1 sees slot0's tag, slot0 sees no bypass.
    applyStimulus();
    setIssue(0, 5'd3, 4'd2);
    setIssue(1, 5'd3, 4'd5);
    issueRs1Addr[0] = 5'd3;
    issueRs1Addr[1] = 5'd3;
    #1;
    checkRead(0, 1, "x3_self", 1'b0, 4'd0, 1'b0);
    checkRead(1, 1, "x3_byp", 1'b1, 4'd2, 1'b0);
    applyStimulus();
    issueRs1Addr[0] = 5'd3;
    #1;
    checkRead(0, 1, "x3_later", 1'b1, 4'd5, 1'b0);

    // Bundle RAW on x7; slot1 reading its own destination x8 sees prior state.
    applyStimulus();
    setIssue(0, 5'd7, 4'd4);
    setIssue(1, 5'd8, 4'd11);
    issueRs1Addr[1] = 5'd7;
    issueRs2Addr[1] = 5'd8;
    #1;
    checkRead(1, 1, "raw_x7", 1'b1, 4'd4, 1'b0);
    checkRead(1, 2, "self_x8", 1'b0, 4'd0, 1'b0);
    applyStimulus();
    issueRs1Addr[0] = 5'd7;
    issueRs2Addr[0] = 5'd8;
    #1;
    checkRead(0, 1, "x7_next", 1'b1, 4'd4, 1'b0);
    checkRead(0, 2, "x8_next", 1'b1, 4'd11, 1'b0);

    // Commit forwarding on x9, then a stale-tag commit that must not clear.
    applyStimulus();
    setIssue(0, 5'd9, 4'd6);
    applyStimulus();
    setCommit(1, 5'd9, 4'd6);
    issueRs1Addr[0] = 5'd9;
    issueRs2Addr[1] = 5'd9;
    #1;
    checkRead(0, 1, "x9_fwd0", 1'b0, 4'd0, 1'b1);
    checkRead(1, 2, "x9_fwd1", 1'b0, 4'd0, 1'b1);
    applyStimulus();
    issueRs1Addr[0] = 5'd9;
    #1;
    checkRead(0, 1, "x9_freed", 1'b0, 4'd0, 1'b0);
    setIssue(0, 5'd9, 4'd6);
    applyStimulus();
    setCommit(0, 5'd9, 4'd3);
    issueRs1Addr[0] = 5'd9;
    #1;
    checkRead(0, 1, "x9_stale", 1'b1, 4'd6, 1'b0);
    applyStimulus();
    issueRs1Addr[0] = 5'd9;
    #1;
    checkRead(0, 1, "x9_kept", 1'b1, 4'd6, 1'b0);

    // Commit and issue of x4 in one cycle: the issue wins.
    applyStimulus();
    setIssue(0, 5'd4, 4'd1);
    applyStimulus();
    setCommit(0, 5'd4, 4'd1);
    setIssue(0, 5'd4, 4'd8);
    issueRs1Addr[1] = 5'd4;
    #1;
    checkRead(1, 1, "x4_byp", 1'b1, 4'd8, 1'b0);
    applyStimulus();
    issueRs1Addr[0] = 5'd4;
    #1;
    checkRead(0, 1, "x4_issue_wins", 1'b1, 4'd8, 1'b0);

    // Register 0 is never busy, even with a write in the bundle.
    applyStimulus();
    setIssue(0, 5'd0, 4'd7);
    issueRs1Addr[1] = 5'd0;
    #1;
    checkRead(1, 1, "x0_byp", 1'b0, 4'd0, 1'b0);
    applyStimulus();
    issueRs1Addr[0] = 5'd0;
    #1;
    checkRead(0, 1, "x0_next", 1'b0, 4'd0, 1'b0);

    // Fill x1..x31 with tag = reg mod 16, then flush with an x2 issue pending.
    for (int r = 1; r <= 31; r += 2) begin
      applyStimulus();
      setIssue(0, 5'(r), 4'(r % 16));
      if (r < 31) setIssue(1, 5'(r + 1), 4'((r + 1) % 16));
    end
    applyStimulus();
    issueRs1Addr[0] = 5'd31;
    issueRs2Addr[0] = 5'd16;
    issueRs1Addr[1] = 5'd2;
    #1;
    checkRead(0, 1, "fill_x31", 1'b1, 4'd15, 1'b0);
    checkRead(0, 2, "fill_x16", 1'b1, 4'd0, 1'b0);
    checkRead(1, 1, "fill_x2", 1'b1, 4'd2, 1'b0);
    applyStimulus();
    flush = 1'b1;
    setIssue(0, 5'd2, 4'd9);
    setCommit(0, 5'd5, 4'd5);
    issueRs1Addr[1] = 5'd2;
    issueRs2Addr[1] = 5'd5;
    #1;
    checkRead(1, 1, "flush_byp_x2", 1'b1, 4'd9, 1'b0);
    checkRead(1, 2, "flush_fwd_x5", 1'b0, 4'd0, 1'b1);
    applyStimulus();
    for (int r = 1; r <= 31; r++) begin
      issueRs1Addr[0] = 5'(r);
      #1;
      checkOutput($sformatf("flushed_x%0d.busy", r), 32'(rs1Busy[0]), 32'd0);
      checkOutput($sformatf("flushed_x%0d.tag", r), 32'(rs1Tag[0]), 32'd0);
    end

    // Reset asserted mid-run clears the table at once; nothing survives it.
    applyStimulus();
    setIssue(0, 5'd5, 4'd3);
    applyStimulus();
    issueRs1Addr[0] = 5'd5;
    #1;
    checkRead(0, 1, "x5_busy", 1'b1, 4'd3, 1'b0);
    #1;
    resetN = 1'b0;
    #1;
    checkRead(0, 1, "midrst_x5", 1'b0, 4'd0, 1'b0);
    setIssue(0, 5'd6, 4'd7);
    applyStimulus();
    resetN = 1'b1;
    issueRs1Addr[0] = 5'd5;
    issueRs2Addr[0] = 5'd6;
    #1;
    checkRead(0, 1, "relrst_x5", 1'b0, 4'd0, 1'b0);
    checkRead(0, 2, "relrst_x6", 1'b0, 4'd0, 1'b0);

`ifdef REGSTAT_CHECKPOINT_EN
    // Save, issue x10, restore: x10 returns to idle and the snapshot is consumed.
    applyStimulus();
    #1;
    checkOutput("ckpt_valid_init", 32'(ckptValid), 32'd0);
    ckptSave = 1'b1;
    applyStimulus();
    #1;
    checkOutput("ckpt_valid_saved", 32'(ckptValid), 32'd1);
    setIssue(0, 5'd10, 4'd3);
    applyStimulus();
    issueRs1Addr[0] = 5'd10;
    #1;
    checkRead(0, 1, "ckpt_x10_busy", 1'b1, 4'd3, 1'b0);
    ckptRestore = 1'b1;
    applyStimulus();
    issueRs1Addr[0] = 5'd10;
    #1;
    checkRead(0, 1, "ckpt_x10_restored", 1'b0, 4'd0, 1'b0);
    checkOutput("ckpt_valid_used", 32'(ckptValid), 32'd0);
`endif

    applyStimulus();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
